// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite fetch: walks the visible-sprite list, fetches one ROM tile
// row per 16-px column and paces we strobes for the downstream line buffer.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | list_addr presented, list RAM read in flight
// LATCH   | list entry valid, register it and set up first column
// FETCH   | rom_req held until rom_ok
// EMIT    | wait for gap counter, then strobe we for the column
module sprite_line_fetch #(
  parameter int LIST_AW = 7,
  parameter int MIN_GAP = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [LIST_AW:0]   list_count,
  output logic               busy,
  output logic               done,
  output logic [LIST_AW-1:0] list_addr,
  input  logic [37:0]        list_data,
  input  logic [3:0]         list_row,
  output logic               rom_req,
  output logic [19:0]        rom_addr,
  input  logic [63:0]        rom_data,
  input  logic               rom_ok,
  output logic [63:0]        bits,
  output logic [6:0]         color,
  output logic               prio,
  output logic [9:0]         pos,
  output logic               we
);

  localparam int GW = $clog2(MIN_GAP);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(MIN_GAP - 1);
  localparam logic [LIST_AW:0] ONE_IDX  = 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_FETCH, S_EMIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [LIST_AW:0]   r_count, w_count_nxt;
  logic [LIST_AW-1:0] r_idx, w_idx_nxt;
  logic [2:0]         r_col, w_col_nxt;
  logic [9:0]         r_x, w_x_nxt;
  logic [6:0]         r_ecolor, w_ecolor_nxt;
  logic               r_eprio, w_eprio_nxt;
  logic               r_flipx, w_flipx_nxt;
  logic [1:0]         r_width, w_width_nxt;
  logic [15:0]        r_code, w_code_nxt;
  logic [3:0]         r_row, w_row_nxt;
  logic [63:0]        r_rdata, w_rdata_nxt;
  logic [GW-1:0]      r_gap, w_gap_nxt;

  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [LIST_AW-1:0] r_list_addr, w_list_addr_nxt;
  logic               r_rom_req, w_rom_req_nxt;
  logic [19:0]        r_rom_addr, w_rom_addr_nxt;
  logic [63:0]        r_bits, w_bits_nxt;
  logic [6:0]         r_color, w_color_nxt;
  logic               r_prio, w_prio_nxt;
  logic [9:0]         r_pos, w_pos_nxt;
  logic               r_we, w_we_nxt;

  logic [LIST_AW:0]   w_idx_inc;
  logic               w_unused;

  assign w_idx_inc = {1'b0, r_idx} + ONE_IDX;
  assign w_unused  = list_data[37];

  function automatic logic [2:0] f_last(input logic [1:0] width);
    return 3'((4'd1 << width) - 4'd1);
  endfunction

  // Flipped sprites walk the columns right-to-left in ROM.
  function automatic logic [19:0] f_rom_addr(input logic [15:0] code, input logic [3:0] row,
                                             input logic [1:0] width, input logic flipx,
                                             input logic [2:0] col);
    logic [2:0] ccol;
    ccol = flipx ? (f_last(width) - col) : col;
    return {code + {13'd0, ccol}, row};
  endfunction

  function automatic logic [63:0] f_lane_rev(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        r[16*p + i] = d[16*p + 15 - i];
      end
    end
    return r;
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_idx_nxt       = r_idx;
    w_col_nxt       = r_col;
    w_x_nxt         = r_x;
    w_ecolor_nxt    = r_ecolor;
    w_eprio_nxt     = r_eprio;
    w_flipx_nxt     = r_flipx;
    w_width_nxt     = r_width;
    w_code_nxt      = r_code;
    w_row_nxt       = r_row;
    w_rdata_nxt     = r_rdata;
    w_gap_nxt       = (r_gap != '0) ? (r_gap - GW'(1)) : '0;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_list_addr_nxt = r_list_addr;
    w_rom_req_nxt   = r_rom_req;
    w_rom_addr_nxt  = r_rom_addr;
    w_bits_nxt      = r_bits;
    w_color_nxt     = r_color;
    w_prio_nxt      = r_prio;
    w_pos_nxt       = r_pos;
    w_we_nxt        = 1'b0;

    // start wins in every state, which is also the abort path
    if (start) begin
      w_count_nxt     = list_count;
      w_idx_nxt       = '0;
      w_list_addr_nxt = '0;
      w_rom_req_nxt   = 1'b0;
      if (list_count == '0) begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end else begin
        w_busy_nxt  = 1'b1;
        w_state_nxt = S_READ;
      end
    end else begin
      case (r_state)
        S_IDLE: ;
        S_READ: w_state_nxt = S_LATCH;
        S_LATCH: begin
          w_x_nxt        = list_data[9:0];
          w_ecolor_nxt   = list_data[16:10];
          w_eprio_nxt    = list_data[17];
          w_flipx_nxt    = list_data[18];
          w_width_nxt    = list_data[20:19];
          w_code_nxt     = list_data[36:21];
          w_row_nxt      = list_row;
          w_col_nxt      = 3'd0;
          w_rom_req_nxt  = 1'b1;
          w_rom_addr_nxt = f_rom_addr(list_data[36:21], list_row, list_data[20:19],
                                      list_data[18], 3'd0);
          w_state_nxt    = S_FETCH;
        end
        S_FETCH: begin
          if (rom_ok) begin
            w_rdata_nxt   = rom_data;
            w_rom_req_nxt = 1'b0;
            w_state_nxt   = S_EMIT;
          end
        end
        S_EMIT: begin
          if (r_gap == '0) begin
            w_we_nxt    = 1'b1;
            w_bits_nxt  = r_flipx ? f_lane_rev(r_rdata) : r_rdata;
            w_color_nxt = r_ecolor;
            w_prio_nxt  = r_eprio;
            w_pos_nxt   = r_x + {3'd0, r_col, 4'd0};
            w_gap_nxt   = GAP_LOAD;
            if (r_col != f_last(r_width)) begin
              w_col_nxt      = r_col + 3'd1;
              w_rom_req_nxt  = 1'b1;
              w_rom_addr_nxt = f_rom_addr(r_code, r_row, r_width, r_flipx, r_col + 3'd1);
              w_state_nxt    = S_FETCH;
            end else if (w_idx_inc < r_count) begin
              w_idx_nxt       = w_idx_inc[LIST_AW-1:0];
              w_list_addr_nxt = w_idx_inc[LIST_AW-1:0];
              w_state_nxt     = S_READ;
            end else begin
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_col       <= '0;
      r_x         <= '0;
      r_ecolor    <= '0;
      r_eprio     <= 1'b0;
      r_flipx     <= 1'b0;
      r_width     <= '0;
      r_code      <= '0;
      r_row       <= '0;
      r_rdata     <= '0;
      r_gap       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_list_addr <= '0;
      r_rom_req   <= 1'b0;
      r_rom_addr  <= '0;
      r_bits      <= '0;
      r_color     <= '0;
      r_prio      <= 1'b0;
      r_pos       <= '0;
      r_we        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_idx       <= w_idx_nxt;
      r_col       <= w_col_nxt;
      r_x         <= w_x_nxt;
      r_ecolor    <= w_ecolor_nxt;
      r_eprio     <= w_eprio_nxt;
      r_flipx     <= w_flipx_nxt;
      r_width     <= w_width_nxt;
      r_code      <= w_code_nxt;
      r_row       <= w_row_nxt;
      r_rdata     <= w_rdata_nxt;
      r_gap       <= w_gap_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_list_addr <= w_list_addr_nxt;
      r_rom_req   <= w_rom_req_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_bits      <= w_bits_nxt;
      r_color     <= w_color_nxt;
      r_prio      <= w_prio_nxt;
      r_pos       <= w_pos_nxt;
      r_we        <= w_we_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign list_addr = r_list_addr;
  assign rom_req   = r_rom_req;
  assign rom_addr  = r_rom_addr;
  assign bits      = r_bits;
  assign color     = r_color;
  assign prio      = r_prio;
  assign pos       = r_pos;
  assign we        = r_we;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: directed corner cases plus random sprite lists,
// checked column-by-column against a list-level reference model.
module tb_sprite_line_fetch;
  localparam int LIST_AW = 7;
  localparam int MIN_GAP = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [LIST_AW:0]   list_count = '0;
  logic               busy, done, rom_req, prio, we;
  logic [LIST_AW-1:0] list_addr;
  logic [37:0]        list_data;
  logic [3:0]         list_row;
  logic [19:0]        rom_addr;
  logic [63:0]        rom_data = '0;
  logic               rom_ok = 1'b0;
  logic [63:0]        bits;
  logic [6:0]         color;
  logic [9:0]         pos;

  always #5 clk = ~clk;

  sprite_line_fetch #(.LIST_AW(LIST_AW), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .list_count(list_count),
    .busy(busy), .done(done), .list_addr(list_addr), .list_data(list_data),
    .list_row(list_row), .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ok(rom_ok), .bits(bits), .color(color), .prio(prio), .pos(pos), .we(we)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] romf(input logic [19:0] a);
    return {a[15:0] ^ 16'hA5C3, a[19:4], ~a[15:0], a[15:0] + 16'h1357};
  endfunction

  function automatic logic [63:0] lanerev(input logic [63:0] d);
    logic [63:0] r;
    for (int p = 0; p < 4; p++)
      for (int px = 0; px < 16; px++) r[16*p + 15 - px] = d[16*p + px];
    return r;
  endfunction

  typedef struct { logic [9:0] x; logic [6:0] color; logic prio; logic flipx;
                   logic [1:0] w; logic [15:0] code; logic [3:0] row; } ent_t;
  typedef struct { logic [19:0] addr; logic [9:0] pos; logic [63:0] bits;
                   logic [6:0] color; logic prio; } col_t;
  typedef struct { logic [9:0] pos; logic [63:0] bits; logic [6:0] color;
                   logic prio; int cyc; } wev_t;

  ent_t ents[$];
  col_t exp_q[$];
  wev_t we_q[$];
  logic [19:0] fetch_q[$];

  logic [37:0] list_mem [0:127];
  logic [3:0]  row_mem  [0:127];

  always @(posedge clk) begin
    list_data <= list_mem[list_addr];
    list_row  <= row_mem[list_addr];
  end

  // ROM responder: acks rom_lat cycles after rom_req; stale_n requests one unsolicited ack
  int rom_lat = 0;
  bit rom_en = 1'b1;
  int rom_wait = 0;
  int stale_n = 0;
  int stale_done = 0;
  always @(negedge clk) begin
    rom_ok = 1'b0;
    if (stale_n != stale_done) begin
      rom_ok = 1'b1;
      rom_data = 64'hDEAD_BEEF_0BAD_F00D;
      stale_done++;
    end else if (rom_en && rom_req) begin
      if (rom_wait >= rom_lat) begin
        rom_ok = 1'b1;
        rom_data = romf(rom_addr);
        fetch_q.push_back(rom_addr);
        rom_wait = 0;
      end else rom_wait++;
    end else rom_wait = 0;
  end

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit busy_seen = 1'b0;
  bit req_seen = 1'b0;
  always @(negedge clk) begin
    wev_t ev;
    cyc++;
    if (we) begin
      ev.pos = pos; ev.bits = bits; ev.color = color; ev.prio = prio; ev.cyc = cyc;
      we_q.push_back(ev);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_seen = 1'b1;
    if (rom_req) req_seen = 1'b1;
  end

  task automatic clear_obs();
    we_q.delete(); fetch_q.delete();
    done_cnt = 0; busy_seen = 1'b0; req_seen = 1'b0;
  endtask

  function automatic ent_t mk(input int x, input int c, input int p, input int f,
                              input int w, input int code, input int row);
    ent_t e;
    e.x = 10'(x); e.color = 7'(c); e.prio = 1'(p); e.flipx = 1'(f);
    e.w = 2'(w); e.code = 16'(code); e.row = 4'(row);
    return e;
  endfunction

  function automatic ent_t rand_ent();
    return mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endfunction

  // Writes ents into list RAM and derives the expected column stream.
  task automatic load_list();
    exp_q.delete();
    foreach (ents[i]) begin
      int nc;
      list_mem[i] = {1'($urandom), ents[i].code, ents[i].w, ents[i].flipx,
                     ents[i].prio, ents[i].color, ents[i].x};
      row_mem[i] = ents[i].row;
      nc = 1 << ents[i].w;
      for (int c = 0; c < nc; c++) begin
        col_t k;
        int cc;
        logic [15:0] cd;
        cc = ents[i].flipx ? (nc - 1 - c) : c;
        cd = 16'((int'(ents[i].code) + cc) % 65536);
        k.addr = {cd, ents[i].row};
        k.bits = ents[i].flipx ? lanerev(romf(k.addr)) : romf(k.addr);
        k.pos = 10'((int'(ents[i].x) + 16 * c) % 1024);
        k.color = ents[i].color;
        k.prio = ents[i].prio;
        exp_q.push_back(k);
      end
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start = 1'b1;
    list_count = (LIST_AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare(input string nm, input bit exact);
    int nw;
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_we_count"}, we_q.size(), exp_q.size());
    chk({nm, "_fetch_count"}, fetch_q.size(), exp_q.size());
    nw = (we_q.size() < exp_q.size()) ? we_q.size() : exp_q.size();
    for (int i = 0; i < nw; i++) begin
      chk({nm, "_pos"}, we_q[i].pos, exp_q[i].pos);
      chk({nm, "_bits"}, we_q[i].bits, exp_q[i].bits);
      chk({nm, "_colprio"}, {we_q[i].color, we_q[i].prio}, {exp_q[i].color, exp_q[i].prio});
      if (i > 0) begin
        if (exact) chk({nm, "_gap"}, we_q[i].cyc - we_q[i-1].cyc, MIN_GAP);
        else chk({nm, "_gap_min"}, (we_q[i].cyc - we_q[i-1].cyc) >= MIN_GAP, 1);
      end
    end
    for (int i = 0; i < fetch_q.size() && i < exp_q.size(); i++)
      chk({nm, "_rom_addr"}, fetch_q[i], exp_q[i].addr);
    if (we_q.size() > 0) chk({nm, "_done_cyc"}, done_cyc, we_q[we_q.size()-1].cyc);
    chk({nm, "_busy_end"}, busy, 0);
  endtask

  task automatic run(input string nm, input int lat, input bit exact);
    load_list();
    rom_lat = lat;
    rom_en = 1'b1;
    @(posedge clk);
    #1 clear_obs();
    pulse_start(ents.size());
    wait_done();
    compare(nm, exact);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin list_mem[i] = '0; row_mem[i] = '0; end
    #12;
    chk("rst_bits", bits, 64'd0);
    chk("rst_ctl", {busy, done, list_addr, rom_req, rom_addr, color, prio, pos, we}, 49'd0);
    @(negedge clk) reset_n = 1'b1;

    ents.delete();
    ents.push_back(mk(100, 7'h2A, 1, 0, 0, 16'h0123, 5));
    run("t1", 0, 1'b1);
    chk("t1_addr", fetch_q.size() > 0 ? fetch_q[0] : 20'hFFFFF, 20'h01235);
    chk("t1_pos", we_q.size() > 0 ? we_q[0].pos : 10'h3FF, 10'd100);

    ents.delete();
    ents.push_back(mk(100, 7'h11, 0, 1, 2, 16'h0010, 3));
    run("t2", 0, 1'b1);
    for (int i = 0; i < 4 && i < fetch_q.size(); i++)
      chk("t2_code", fetch_q[i][19:4], 16'h13 - 16'(i));
    for (int i = 0; i < 4 && i < we_q.size(); i++)
      chk("t2_pos", we_q[i].pos, 10'(100 + 16 * i));

    ents.delete();
    ents.push_back(mk(40, 3, 0, 0, 1, 16'h0200, 1));
    ents.push_back(mk(300, 9, 1, 1, 1, 16'h0300, 2));
    run("t3", 0, 1'b1);

    ents.delete();
    ents.push_back(mk(1016, 5, 0, 0, 1, 16'h0400, 7));
    ents.push_back(mk(500, 6, 1, 0, 1, 16'hFFFF, 8));
    run("t4", 1, 1'b0);
    chk("t4_pos_wrap", we_q.size() > 1 ? we_q[1].pos : 10'h3FF, 10'd8);
    chk("t4_code_wrap", fetch_q.size() > 3 ? fetch_q[3][19:4] : 16'h5555, 16'h0000);

    @(posedge clk);
    #1 clear_obs();
    pulse_start(0);
    #1 chk("t5_done_next", done, 1);
    repeat (20) @(negedge clk);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_busy_seen", busy_seen, 0);
    chk("t5_req_seen", req_seen, 0);
    chk("t5_we_count", we_q.size(), 0);

    ents.delete();
    for (int i = 0; i < 3; i++) ents.push_back(rand_ent());
    load_list();
    rom_en = 1'b0;
    @(posedge clk);
    #1 clear_obs();
    pulse_start(3);
    for (int k = 0; k < 100 && !rom_req; k++) @(negedge clk);
    chk("t6_req_seen", rom_req, 1);
    ents.delete();
    for (int i = 0; i < 2; i++) ents.push_back(rand_ent());
    load_list();
    rom_lat = 0;
    pulse_start(2);
    #1;
    chk("t6_req_drop", rom_req, 0);
    chk("t6_addr0", list_addr, 0);
    chk("t6_busy", busy, 1);
    stale_n++;
    rom_en = 1'b1;
    wait_done();
    compare("t6", 1'b1);

    ents.delete();
    ents.push_back(mk(200, 4, 1, 0, 2, 16'h0777, 9));
    load_list();
    rom_lat = 0;
    @(posedge clk);
    #1 clear_obs();
    pulse_start(1);
    for (int k = 0; k < 100 && we_q.size() == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t7_busy_mid", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t7_rst_bits", bits, 64'd0);
    chk("t7_rst_ctl", {busy, done, list_addr, rom_req, rom_addr, color, prio, pos, we}, 49'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t7_no_done", done_cnt, 0);
    chk("t7_we_count", we_q.size(), 1);

    for (int it = 0; it < 8; it++) begin
      int n, lat;
      n = $urandom_range(1, 6);
      lat = $urandom_range(0, 3);
      ents.delete();
      for (int i = 0; i < n; i++) ents.push_back(rand_ent());
      run("rnd", lat, lat == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
